sync_fifo_asym: RTL
===================

Name: sync_fifo_asym

Overview:
Parametrised single-clock FIFO with independent write and read widths, covering both wide-to-narrow and narrow-to-wide ratios.
It offers Standard and FWFT read modes, LSB/MSB-first unpacking order, and programmable-threshold flags.
It is the in-house replacement for vendor sync FIFOs in width-conversion datapaths, for example 64-bit bus to 8-bit byte stream and the reverse.
Storage is held at the granularity of the narrower width ("unit").

Parameters:
INPUT_WIDTH, 64, write word width; power-of-two multiple or divisor of OUTPUT_WIDTH
OUTPUT_WIDTH, 8, read word width
WR_DEPTH, 16, capacity in write words; WR_DEPTH*INPUT_WIDTH must equal RD_DEPTH*OUTPUT_WIDTH
RD_DEPTH, 128, capacity in read words
MODE, "Standard", "Standard" (registered dout, 1-cycle latency) or "FWFT"
DIRECTION, "LSB", "LSB": first unit occupies din/dout[MIN_W-1:0]; "MSB": top bits first
PROG_FULL_THRESH, 12, prog_full when wr_data_count >= value
PROG_EMPTY_THRESH, 4, prog_empty when rd_data_count <= value

Ports:
sys_clk  in  1  clock
sys_rst  in  1  asynchronous reset, active-high
wr_en  in  1  write request
din  in  INPUT_WIDTH  write data
rd_en  in  1  read request (Standard) / pop acknowledge (FWFT)
dout  out  OUTPUT_WIDTH  read data
valid  out  1  dout holds a read word
full  out  1  no room for one write word
empty  out  1  fewer than one read word stored
overflow  out  1  1-cycle pulse: write rejected
underflow  out  1  1-cycle pulse: read rejected
prog_full  out  1  threshold flag
prog_empty  out  1  threshold flag
wr_data_count  out  clog2(WR_DEPTH)+1  stored data in write words, floor
rd_data_count  out  clog2(RD_DEPTH)+1  stored data in read words, floor
wr_data_space  out  clog2(WR_DEPTH)+1  free space in write words, floor
rd_data_space  out  clog2(RD_DEPTH)+1  free space in read words, floor

Behaviour:
- Definitions: MIN_W = min(IN,OUT); U_IN = IN/MIN_W; U_OUT = OUT/MIN_W; CAP = WR_DEPTH*U_IN units.
- State: wr_ptr and rd_ptr are unit indices mod CAP; ucount holds 0..CAP units.
- Reset (asynchronous assert, sys_rst high):
  - pointers = 0, ucount = 0.
  - dout = 0, valid = 0, empty = 1, full = 0, overflow = 0, underflow = 0, prog_full = 0, prog_empty = 1.
  - counts = 0; wr_data_space = WR_DEPTH; rd_data_space = RD_DEPTH.
  - Reset mid-operation discards all contents. No output glitches on release.
- Flags and counts are combinational from the registered ucount:
  - full = (CAP-ucount) < U_IN; empty = ucount < U_OUT.
  - wr_data_count = ucount/U_IN; rd_data_count = ucount/U_OUT.
  - Spaces are (CAP-ucount)/U_IN and (CAP-ucount)/U_OUT.
- Write acceptance: wr_en & ~full.
  - Writes U_IN units at wr_ptr..wr_ptr+U_IN-1 (mod CAP), in DIRECTION order.
  - wr_ptr += U_IN.
- Read acceptance:
  - Standard: rd_en & ~empty.
  - FWFT: rd_en & valid.
  - Consumes U_OUT units; rd_ptr += U_OUT.
- Simultaneous accepted write and read:
  - Both are judged on pre-cycle state.
  - ucount_next = ucount + U_IN*w - U_OUT*r.
  - A write while full is rejected even if a read happens in the same cycle.
  - A read while empty is rejected even if a write happens in the same cycle.
- Rejected write: overflow = 1 on the next cycle; no state change. Rejected read: underflow = 1 on the next cycle.
- Standard mode:
  - Accepted read: dout is loaded on the next edge and valid = 1 for exactly that cycle.
  - Otherwise valid = 0 and dout holds its last value.
- FWFT mode:
  - valid = ~empty; dout presents the head read word combinationally.
  - rd_en pops the head.
  - First-word latency after a write that crosses U_OUT: one cycle (ucount update).
- Packing:
  - With LSB, unit k of a word maps to bits [k*MIN_W +: MIN_W].
  - With MSB, unit k maps to bits [(U-1-k)*MIN_W +: MIN_W].
  - The same rule applies to both sides.
- Pointer wrap: modulo CAP. CAP need not be a power of two; explicit compare-and-subtract is used.
- prog_full and prog_empty are registered, updated from ucount_next.

Decomposition:
- Package fifo_asym_pkg holds:
  - clog2 helper, MIN_W/U_IN/U_OUT/CAP derivation functions.
  - MODE_STD/MODE_FWFT and DIR_LSB/DIR_MSB constants.
  - Elaboration-time parameter-consistency check.
- Sub-module sync_fifo_asym_ram: unit-granular register array with a U_IN-unit write port and a U_OUT-unit asynchronous read port, with wrap handled internally.
- Top-level logic covers pointers, ucount, flags, and the mode-specific output stage.

Test Plan:
- Reset, default parameters: sys_rst = 1 → empty = 1, full = 0, wr_data_space = 16, rd_data_space = 128, dout = 0, valid = 0; release → unchanged until first write.
- 64→8, Standard, LSB: write 0x0123456789abcdef, then rd_en for 8 cycles → valid one cycle after each rd_en; dout = ef, cd, ab, 89, 67, 45, 23, 01; rd_data_count 8→0, then empty = 1.
- Fill 64→8: 16 writes → full = 1, wr_data_count = 16, rd_data_count = 128, prog_full = 1 from count 12; 17th wr_en → overflow pulse, counts unchanged.
- 8→64, FWFT, MSB: write bytes 01..08 → after 8th write plus 1 cycle, valid = 1, dout = 0x0102030405060708 with no rd_en; rd_en → empty = 1, valid = 0.
- Concurrency 64→8: rd_data_count = 8, wr_en & rd_en same cycle → rd_data_count = 15. Full with wr_en & rd_en → write rejected (overflow), rd_data_count = 127.
- Error and reset: rd_en while empty → underflow pulse, valid = 0, dout held. sys_rst pulse mid-stream with 5 words stored → counts = 0, empty = 1, subsequent data is post-reset writes only.

Source files
------------

// File: rtl/fifo_asym_pkg.sv
// fifo_asym_pkg: shared constants and geometry helpers for the asymmetric FIFO.
package fifo_asym_pkg;
  localparam string MODE_STD = "Standard";
  localparam string MODE_FWFT = "FWFT";
  localparam string DIR_LSB = "LSB";
  localparam string DIR_MSB = "MSB";
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction
  function automatic int min_w(input int iw, input int ow);
    return iw < ow ? iw : ow;
  endfunction
  function automatic int u_in(input int iw, input int ow);
    return iw / min_w(iw, ow);
  endfunction
  function automatic int u_out(input int iw, input int ow);
    return ow / min_w(iw, ow);
  endfunction
  function automatic int cap_units(input int iw, input int ow, input int wd);
    return wd * u_in(iw, ow);
  endfunction
  function automatic int ptr_w(input int cap);
    return clog2(cap) < 1 ? 1 : clog2(cap);
  endfunction
  function automatic bit is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
  function automatic int wrap_add(input int p, input int u, input int cap);
    return p + u >= cap ? p + u - cap : p + u;
  endfunction
  function automatic bit cfg_ok(input int iw, input int ow, input int wd, input int rd);
    int lo;
    int hi;
    lo = min_w(iw, ow);
    hi = iw < ow ? ow : iw;
    return lo > 0 && hi % lo == 0 && is_pow2(hi / lo) && wd > 0 && wd * iw == rd * ow;
  endfunction
endpackage

// File: rtl/sync_fifo_asym_ram.sv
// sync_fifo_asym_ram: unit-granular storage with a multi-unit write port and async multi-unit read port.
module sync_fifo_asym_ram
  import fifo_asym_pkg::*;
#(
  parameter int MW = 8,
  parameter int UI = 8,
  parameter int UO = 1,
  parameter int CAP = 128,
  parameter int PW = 7
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_ptr,
  input  logic [UI*MW-1:0] wr_units,
  input  logic [PW-1:0]    rd_ptr,
  output logic [UO*MW-1:0] rd_units
);
  logic [MW-1:0] mem_q [CAP];
  always_ff @(posedge clk)
    if (wr_en)
      for (int k = 0; k < UI; k++)
        mem_q[PW'(wrap_add(int'(wr_ptr), k, CAP))] <= wr_units[k*MW +: MW];
  always_comb begin
    rd_units = '0;
    for (int k = 0; k < UO; k++)
      rd_units[k*MW +: MW] = mem_q[PW'(wrap_add(int'(rd_ptr), k, CAP))];
  end
endmodule

// File: rtl/sync_fifo_asym.sv
// sync_fifo_asym: single-clock FIFO with independent write/read widths, Standard or FWFT reads.
module sync_fifo_asym
  import fifo_asym_pkg::*;
#(
  parameter int INPUT_WIDTH = 64,
  parameter int OUTPUT_WIDTH = 8,
  parameter int WR_DEPTH = 16,
  parameter int RD_DEPTH = 128,
  parameter string MODE = "Standard",
  parameter string DIRECTION = "LSB",
  parameter int PROG_FULL_THRESH = 12,
  parameter int PROG_EMPTY_THRESH = 4,
  localparam int WCW = clog2(WR_DEPTH) + 1,
  localparam int RCW = clog2(RD_DEPTH) + 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    wr_en,
  input  logic [INPUT_WIDTH-1:0]  din,
  input  logic                    rd_en,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    valid,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    prog_full,
  output logic                    prog_empty,
  output logic [WCW-1:0]          wr_data_count,
  output logic [RCW-1:0]          rd_data_count,
  output logic [WCW-1:0]          wr_data_space,
  output logic [RCW-1:0]          rd_data_space
);
  localparam int MW = min_w(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int UI = u_in(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int UO = u_out(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int CAP = cap_units(INPUT_WIDTH, OUTPUT_WIDTH, WR_DEPTH);
  localparam int PW = ptr_w(CAP);
  localparam int CW = clog2(CAP + 1);
  localparam bit FWFT = MODE == MODE_FWFT;
  localparam bit MSB = DIRECTION == DIR_MSB;
  if (!cfg_ok(INPUT_WIDTH, OUTPUT_WIDTH, WR_DEPTH, RD_DEPTH) ||
      !(MODE == MODE_STD || MODE == MODE_FWFT) ||
      !(DIRECTION == DIR_LSB || DIRECTION == DIR_MSB)) begin : g_bad_cfg
    $error("sync_fifo_asym: inconsistent parameters");
  end
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ucount_q, ucount_d, free;
  logic [OUTPUT_WIDTH-1:0] dout_q, dout_d, rd_word, rd_units;
  logic [INPUT_WIDTH-1:0] wr_units;
  logic valid_q, valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic prog_full_q, prog_full_d, prog_empty_q, prog_empty_d;
  logic wr_acc, rd_acc;
  // Storage is always unit-ordered; DIRECTION only changes how words map onto units.
  always_comb begin
    wr_units = '0;
    rd_word = '0;
    for (int k = 0; k < UI; k++)
      wr_units[k*MW +: MW] = din[(MSB ? UI - 1 - k : k)*MW +: MW];
    for (int k = 0; k < UO; k++)
      rd_word[(MSB ? UO - 1 - k : k)*MW +: MW] = rd_units[k*MW +: MW];
  end
  assign free = CW'(CAP) - ucount_q;
  assign full = free < CW'(UI);
  assign empty = ucount_q < CW'(UO);
  assign wr_acc = wr_en & ~full;
  // In FWFT valid equals ~empty, so both modes accept reads on the same condition.
  assign rd_acc = rd_en & ~empty;
  always_comb begin
    wr_ptr_d = wr_acc ? PW'(wrap_add(int'(wr_ptr_q), UI, CAP)) : wr_ptr_q;
    rd_ptr_d = rd_acc ? PW'(wrap_add(int'(rd_ptr_q), UO, CAP)) : rd_ptr_q;
    ucount_d = ucount_q + (wr_acc ? CW'(UI) : CW'(0)) - (rd_acc ? CW'(UO) : CW'(0));
    overflow_d = wr_en & full;
    underflow_d = rd_en & empty;
    prog_full_d = int'(ucount_d / CW'(UI)) >= PROG_FULL_THRESH;
    prog_empty_d = int'(ucount_d / CW'(UO)) <= PROG_EMPTY_THRESH;
    valid_d = rd_acc & ~FWFT;
    dout_d = rd_acc ? rd_word : dout_q;
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ucount_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
      prog_full_q <= 1'b0;
      prog_empty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ucount_q <= ucount_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
      prog_full_q <= prog_full_d;
      prog_empty_q <= prog_empty_d;
    end
  sync_fifo_asym_ram #(.MW(MW), .UI(UI), .UO(UO), .CAP(CAP), .PW(PW)) u_ram (
    .clk(sys_clk),
    .wr_en(wr_acc),
    .wr_ptr(wr_ptr_q),
    .wr_units(wr_units),
    .rd_ptr(rd_ptr_q),
    .rd_units(rd_units)
  );
  assign dout = FWFT ? (empty ? '0 : rd_word) : dout_q;
  assign valid = FWFT ? ~empty : valid_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  assign prog_full = prog_full_q;
  assign prog_empty = prog_empty_q;
  assign wr_data_count = WCW'(ucount_q / CW'(UI));
  assign rd_data_count = RCW'(ucount_q / CW'(UO));
  assign wr_data_space = WCW'(free / CW'(UI));
  assign rd_data_space = RCW'(free / CW'(UO));
endmodule
